// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DONE
  } state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fifo_entry_t;

  typedef struct packed {
    logic              valid;
    logic              epoch;
    logic [ADDR_W-1:0] pc;
  } stage_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch bus bundle: instruction-memory port, redirect input and decode handshake.
interface fetch_if;
  import fetch_pkg::*;

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               fetch_done;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc, fetch_done,
    input  mem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc, fetch_done,
    output mem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer: circular FIFO with simultaneous push/pop and a one-cycle flush.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Flush wins over a same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) slots[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= push_data;
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC/state control, fixed-latency read tracking with
// epoch tagging for redirects, and a fetch buffer feeding decode.
module fetch_controller import fetch_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned       MEM_WORDS   = 32,
  parameter int unsigned       MEM_LATENCY = 1,
  parameter int unsigned       FIFO_DEPTH  = 4
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = 8;
  localparam logic [ADDR_W-1:0] END_PC = ADDR_W'(MEM_WORDS * 4);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              epoch_q, epoch_d;
  logic              issue;
  stage_t            stages [MEM_LATENCY];
  logic [OCC_W-1:0]  inflight;
  logic [OCC_W-1:0]  occ;
  logic [CNT_W-1:0]  count;
  logic              head_valid;
  logic              pop;
  logic              push;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;

  // Occupancy includes every outstanding read, stale or not, so the buffer never overflows.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(MEM_LATENCY); i++) inflight = inflight + OCC_W'(stages[i].valid);
  end

  assign head_valid = (count != '0);
  assign pop        = head_valid & bus.out_ready;
  assign occ        = OCC_W'(count) + inflight - OCC_W'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC & ~ADDR_W'(3);
      epoch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;
    issue   = 1'b0;
    if (bus.redirect_valid) begin
      epoch_d = ~epoch_q;
      pc_d    = bus.redirect_pc & ~ADDR_W'(3);
      state_d = (pc_d >= END_PC) ? DONE : RUN;
    end else begin
      case (state_q)
        BOOT: state_d = RUN;
        RUN: begin
          if (occ < OCC_W'(FIFO_DEPTH)) begin
            issue = 1'b1;
            pc_d  = pc_q + ADDR_W'(4);
            if (pc_d >= END_PC) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Read-latency tracker; the oldest stage lines up with mem_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(MEM_LATENCY); i++) stages[i] <= '0;
    end else begin
      stages[0].valid <= issue;
      stages[0].epoch <= epoch_q;
      stages[0].pc    <= pc_q;
      for (int i = 1; i < int'(MEM_LATENCY); i++) stages[i] <= stages[i-1];
    end
  end

  assign push             = stages[MEM_LATENCY-1].valid && (stages[MEM_LATENCY-1].epoch == epoch_q);
  assign push_entry.instr = bus.mem_rdata;
  assign push_entry.pc    = stages[MEM_LATENCY-1].pc;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .head      (head),
    .count     (count)
  );

  assign bus.mem_req    = issue;
  assign bus.mem_addr   = pc_q;
  assign bus.out_valid  = head_valid;
  assign bus.out_instr  = head.instr;
  assign bus.out_pc     = head.pc;
  assign bus.fetch_done = (state_q == DONE);

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: latency-1 and latency-3 instances against a stream-level
// model (expected pc advances by 4 per accepted word and restarts at each redirect target).
`timescale 1ns/1ps
module tb_fetch_controller;
  import fetch_pkg::*;

  localparam int unsigned MEM_WORDS = 32;
  localparam int          LAT1      = 1;
  localparam int          LAT3      = 3;
  localparam logic [ADDR_W-1:0] END_PC = 32'h0000_0080;

  logic clk;
  logic rst1;
  logic rst3;
  logic [31:0] imem [MEM_WORDS];
  logic [31:0] rq1;
  logic [31:0] rq3 [3];
  int checks;
  int failures;

  fetch_if if1 ();
  fetch_if if3 ();

  fetch_controller #(.RESET_PC(32'h0), .MEM_WORDS(MEM_WORDS), .MEM_LATENCY(LAT1), .FIFO_DEPTH(4))
    dut1 (.clk(clk), .rst(rst1), .bus(if1));
  fetch_controller #(.RESET_PC(32'h0), .MEM_WORDS(MEM_WORDS), .MEM_LATENCY(LAT3), .FIFO_DEPTH(4))
    dut3 (.clk(clk), .rst(rst3), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory with fixed read latency per instance.
  always @(posedge clk) begin
    rq1    <= if1.mem_req ? imem[if1.mem_addr[6:2]] : 32'h0;
    rq3[0] <= if3.mem_req ? imem[if3.mem_addr[6:2]] : 32'h0;
    rq3[1] <= rq3[0];
    rq3[2] <= rq3[1];
  end
  assign if1.mem_rdata = rq1;
  assign if3.mem_rdata = rq3[2];

  function automatic logic [31:0] ref_instr(input logic [31:0] pc);
    return imem[pc[6:2]];
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut1();
    rst1 = 1'b1;
    if1.redirect_valid = 1'b0;
    if1.redirect_pc = 32'h0;
    if1.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst1 = 1'b0;
  endtask

  task automatic test_reset();
    rst1 = 1'b1;
    if1.out_ready = 1'b1;
    if1.redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({if1.mem_req, if1.out_valid, if1.fetch_done} !== 3'b000 || if1.mem_addr !== 32'h0 ||
        if1.out_instr !== 32'h0 || if1.out_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_values req=%b valid=%b done=%b addr=%h instr=%h pc=%h, want all zero",
               if1.mem_req, if1.out_valid, if1.fetch_done, if1.mem_addr, if1.out_instr, if1.out_pc);
    end
    @(posedge clk);
    #1 rst1 = 1'b0;
    @(negedge clk);
    checks++;
    if (if1.mem_req !== 1'b0 || if1.fetch_done !== 1'b0) begin
      failures++;
      $display("FAIL boot_no_req req=%b done=%b want 0 0", if1.mem_req, if1.fetch_done);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (if1.mem_req !== 1'b1 || if1.mem_addr !== 32'h0) begin
      failures++;
      $display("FAIL first_req req=%b addr=%h want 1 00000000", if1.mem_req, if1.mem_addr);
    end
    next_cycle();
  endtask

  task automatic test_basic();
    logic [31:0] exp_pc;
    reset_dut1();
    if1.out_ready = 1'b1;
    exp_pc = 32'h0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checks++;
      if (if1.out_valid !== (k >= 2 + LAT1)) begin
        failures++;
        $display("FAIL basic_valid cycle=%0d got=%b want=%b", k, if1.out_valid, (k >= 2 + LAT1));
      end
      if (if1.out_valid === 1'b1) begin
        checks++;
        if (if1.out_pc !== exp_pc || if1.out_instr !== ref_instr(exp_pc)) begin
          failures++;
          $display("FAIL basic_word cycle=%0d pc=%h instr=%h want pc=%h instr=%h",
                   k, if1.out_pc, if1.out_instr, exp_pc, ref_instr(exp_pc));
        end
        exp_pc += 32'd4;
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_pc;
    int nreq;
    reset_dut1();
    nreq = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (if1.mem_req === 1'b1) nreq++;
      if (k == 9) begin
        checks++;
        if (if1.mem_req !== 1'b0 || if1.out_valid !== 1'b1 || if1.out_pc !== 32'h0) begin
          failures++;
          $display("FAIL stall_hold req=%b valid=%b pc=%h want 0 1 00000000",
                   if1.mem_req, if1.out_valid, if1.out_pc);
        end
      end
      next_cycle();
    end
    checks++;
    if (nreq != 4) begin
      failures++;
      $display("FAIL stall_reqs got=%0d want=4", nreq);
    end
    if1.out_ready = 1'b1;
    exp_pc = 32'h0;
    for (int k = 10; k < 22; k++) begin
      @(negedge clk);
      if (k == 10) begin
        checks++;
        if (if1.mem_req !== 1'b1 || if1.mem_addr !== 32'h10) begin
          failures++;
          $display("FAIL stall_resume req=%b addr=%h want 1 00000010", if1.mem_req, if1.mem_addr);
        end
      end
      if (if1.out_valid === 1'b1) begin
        checks++;
        if (if1.out_pc !== exp_pc || if1.out_instr !== ref_instr(exp_pc)) begin
          failures++;
          $display("FAIL stall_word cycle=%0d pc=%h instr=%h want pc=%h instr=%h",
                   k, if1.out_pc, if1.out_instr, exp_pc, ref_instr(exp_pc));
        end
        exp_pc += 32'd4;
      end
      next_cycle();
    end
    checks++;
    if (exp_pc !== 32'h30) begin
      failures++;
      $display("FAIL stall_drain delivered_up_to=%h want=00000030", exp_pc);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc;
    reset_dut1();
    repeat (4) next_cycle();
    if1.redirect_valid = 1'b1;
    if1.redirect_pc = 32'h0000_0009;
    @(negedge clk);
    checks++;
    if (if1.mem_req !== 1'b0 || if1.out_valid !== 1'b1 || if1.out_pc !== 32'h0) begin
      failures++;
      $display("FAIL redir_cycle req=%b valid=%b pc=%h want 0 1 00000000",
               if1.mem_req, if1.out_valid, if1.out_pc);
    end
    next_cycle();
    if1.redirect_valid = 1'b0;
    if1.out_ready = 1'b1;
    exp_pc = 32'h8;
    for (int k = 5; k < 13; k++) begin
      @(negedge clk);
      if (k == 5) begin
        checks++;
        if (if1.mem_req !== 1'b1 || if1.mem_addr !== 32'h8) begin
          failures++;
          $display("FAIL redir_req req=%b addr=%h want 1 00000008", if1.mem_req, if1.mem_addr);
        end
      end
      checks++;
      if (if1.out_valid !== (k >= 4 + 2 + LAT1)) begin
        failures++;
        $display("FAIL redir_valid cycle=%0d got=%b want=%b", k, if1.out_valid, (k >= 4 + 2 + LAT1));
      end
      if (if1.out_valid === 1'b1) begin
        checks++;
        if (if1.out_pc !== exp_pc || if1.out_instr !== ref_instr(exp_pc)) begin
          failures++;
          $display("FAIL redir_word cycle=%0d pc=%h instr=%h want pc=%h instr=%h",
                   k, if1.out_pc, if1.out_instr, exp_pc, ref_instr(exp_pc));
        end
        exp_pc += 32'd4;
      end
      next_cycle();
    end
  endtask

  task automatic test_done();
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    int issued;
    int pops;
    reset_dut1();
    if1.out_ready = 1'b1;
    exp_pc = 32'h0;
    exp_req = 32'h0;
    issued = 0;
    pops = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (if1.fetch_done !== (issued == int'(MEM_WORDS))) begin
        failures++;
        $display("FAIL done_flag cycle=%0d got=%b want=%b", k, if1.fetch_done, (issued == int'(MEM_WORDS)));
      end
      if (if1.mem_req === 1'b1) begin
        checks++;
        if (issued == int'(MEM_WORDS) || if1.mem_addr !== exp_req) begin
          failures++;
          $display("FAIL done_req cycle=%0d addr=%h want addr=%h issued=%0d", k, if1.mem_addr, exp_req, issued);
        end
        exp_req += 32'd4;
        issued++;
      end
      if (if1.out_valid === 1'b1) begin
        checks++;
        if (if1.out_pc !== exp_pc || if1.out_instr !== ref_instr(exp_pc)) begin
          failures++;
          $display("FAIL done_word cycle=%0d pc=%h want=%h", k, if1.out_pc, exp_pc);
        end
        exp_pc += 32'd4;
        pops++;
      end
      next_cycle();
    end
    checks++;
    if (pops != int'(MEM_WORDS) || issued != int'(MEM_WORDS)) begin
      failures++;
      $display("FAIL done_totals pops=%0d issued=%0d want %0d", pops, issued, MEM_WORDS);
    end
    if1.redirect_valid = 1'b1;
    if1.redirect_pc = 32'h4;
    @(negedge clk);
    next_cycle();
    if1.redirect_valid = 1'b0;
    exp_pc = 32'h4;
    for (int k = 41; k < 47; k++) begin
      @(negedge clk);
      if (k == 41) begin
        checks++;
        if (if1.fetch_done !== 1'b0 || if1.mem_req !== 1'b1 || if1.mem_addr !== 32'h4) begin
          failures++;
          $display("FAIL restart done=%b req=%b addr=%h want 0 1 00000004",
                   if1.fetch_done, if1.mem_req, if1.mem_addr);
        end
      end
      checks++;
      if (if1.out_valid !== (k >= 40 + 2 + LAT1)) begin
        failures++;
        $display("FAIL restart_valid cycle=%0d got=%b", k, if1.out_valid);
      end
      if (if1.out_valid === 1'b1) begin
        checks++;
        if (if1.out_pc !== exp_pc || if1.out_instr !== ref_instr(exp_pc)) begin
          failures++;
          $display("FAIL restart_word pc=%h instr=%h want pc=%h instr=%h",
                   if1.out_pc, if1.out_instr, exp_pc, ref_instr(exp_pc));
        end
        exp_pc += 32'd4;
      end
      next_cycle();
    end
    if1.redirect_valid = 1'b1;
    if1.redirect_pc = END_PC;
    @(negedge clk);
    next_cycle();
    if1.redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (if1.fetch_done !== 1'b1 || if1.mem_req !== 1'b0 || if1.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL redir_past_end done=%b req=%b valid=%b want 1 0 0",
                 if1.fetch_done, if1.mem_req, if1.out_valid);
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_pc;
    reset_dut1();
    if1.out_ready = 1'b1;
    repeat (6) next_cycle();
    @(negedge clk);
    checks++;
    if (if1.out_valid !== 1'b1 || if1.mem_req !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre valid=%b req=%b want 1 1", if1.out_valid, if1.mem_req);
    end
    #1 rst1 = 1'b1;
    #1;
    checks++;
    if ({if1.mem_req, if1.out_valid, if1.fetch_done} !== 3'b000 || if1.mem_addr !== 32'h0 ||
        if1.out_instr !== 32'h0 || if1.out_pc !== 32'h0) begin
      failures++;
      $display("FAIL areset_values req=%b valid=%b done=%b addr=%h instr=%h pc=%h, want all zero",
               if1.mem_req, if1.out_valid, if1.fetch_done, if1.mem_addr, if1.out_instr, if1.out_pc);
    end
    next_cycle();
    rst1 = 1'b0;
    exp_pc = 32'h0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (if1.out_valid !== (k >= 2 + LAT1)) begin
        failures++;
        $display("FAIL areset_valid cycle=%0d got=%b want=%b", k, if1.out_valid, (k >= 2 + LAT1));
      end
      if (if1.out_valid === 1'b1) begin
        checks++;
        if (if1.out_pc !== exp_pc || if1.out_instr !== ref_instr(exp_pc)) begin
          failures++;
          $display("FAIL areset_word pc=%h instr=%h want pc=%h instr=%h",
                   if1.out_pc, if1.out_instr, exp_pc, ref_instr(exp_pc));
        end
        exp_pc += 32'd4;
      end
      next_cycle();
    end
  endtask

  task automatic test_latency3_random();
    logic [31:0] exp_pc;
    logic [31:0] target;
    logic [31:0] last_target;
    int blank;
    int pops;
    int phase;
    bit redir;
    bit prev_redir;
    rst3 = 1'b1;
    if3.redirect_valid = 1'b0;
    if3.redirect_pc = 32'h0;
    if3.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst3 = 1'b0;
    exp_pc = 32'h0;
    last_target = 32'h0;
    blank = 0;
    pops = 0;
    prev_redir = 1'b0;
    phase = int'($urandom_range(0, 1));
    for (int k = 0; k < 300; k++) begin
      if3.out_ready = (k < 150) ? (((k + phase) % 2) == 1) : ($urandom_range(0, 1) == 1);
      redir = (k > 10) && !prev_redir && ($urandom_range(0, 15) == 0);
      target = 32'($urandom_range(0, 35)) * 32'd4 + 32'($urandom_range(0, 3));
      if3.redirect_valid = redir;
      if3.redirect_pc = target;
      @(negedge clk);
      checks++;
      if (dut3.u_fifo.push === 1'b1 && dut3.u_fifo.pop !== 1'b1 && dut3.u_fifo.flush !== 1'b1 &&
          dut3.u_fifo.count == 3'd4) begin
        failures++;
        $display("FAIL fifo_full_push cycle=%0d count=%0d want no push into full buffer", k, dut3.u_fifo.count);
      end
      if (prev_redir) begin
        checks++;
        if (if3.fetch_done !== (last_target >= END_PC)) begin
          failures++;
          $display("FAIL l3_done cycle=%0d target=%h got=%b want=%b",
                   k, last_target, if3.fetch_done, (last_target >= END_PC));
        end
      end
      if (blank > 0) begin
        checks++;
        if (if3.out_valid !== 1'b0) begin
          failures++;
          $display("FAIL l3_blank cycle=%0d valid=%b want 0", k, if3.out_valid);
        end
        blank--;
      end
      if (if3.out_valid === 1'b1 && if3.out_ready === 1'b1) begin
        checks++;
        if (if3.out_pc !== exp_pc || if3.out_instr !== ref_instr(exp_pc) || exp_pc >= END_PC) begin
          failures++;
          $display("FAIL l3_word cycle=%0d pc=%h instr=%h want pc=%h instr=%h",
                   k, if3.out_pc, if3.out_instr, exp_pc, ref_instr(exp_pc));
        end
        exp_pc += 32'd4;
        pops++;
      end
      if (redir) begin
        exp_pc = target & ~32'h3;
        last_target = target & ~32'h3;
        blank = LAT3 + 1;
      end
      prev_redir = redir;
      next_cycle();
    end
    if3.redirect_valid = 1'b0;
    checks++;
    if (pops < 20) begin
      failures++;
      $display("FAIL l3_progress pops=%0d want at least 20", pops);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst1 = 1'b1;
    rst3 = 1'b1;
    if1.redirect_valid = 1'b0;
    if1.redirect_pc = 32'h0;
    if1.out_ready = 1'b0;
    if3.redirect_valid = 1'b0;
    if3.redirect_pc = 32'h0;
    if3.out_ready = 1'b0;
    for (int i = 0; i < int'(MEM_WORDS); i++) imem[i] = $urandom;
    imem[0] = 32'h8b1f03e5;
    imem[1] = 32'hf84000a4;
    imem[2] = 32'h8b040086;
    imem[3] = 32'hf80010a6;
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_done();
    test_async_reset();
    test_latency3_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Instruction-fetch sequencer for the ARMv8 core. Owns the program counter, issues word reads to the instruction memory with a fixed read latency, buffers returned words in a small FIFO, and presents them to decode over a valid/ready handshake. It also handles branch redirects by discarding in-flight and buffered words, and it stops fetching at the end of the instruction memory.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- MEM_WORDS, 32: instruction memory depth in 32-bit words.
- MEM_LATENCY, 1: cycles from `mem_req` to valid `mem_rdata`; allowed range 1..3.
- FIFO_DEPTH, 4: fetch buffer entries; must be ≥ MEM_LATENCY+1.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  read strobe to instruction memory.
- mem_addr  out  32  word-aligned byte address; memory indexes `mem_addr[6:2]`.
- mem_rdata  in  32  read data, valid exactly MEM_LATENCY cycles after `mem_req`.
- redirect_valid  in  1  branch/exception redirect, single-cycle pulse.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 0).
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts.
- out_instr  out  32  instruction word.
- out_pc  out  32  byte address of `out_instr`.
- fetch_done  out  1  fetch PC has passed the end of memory; no further requests.

## Operation
- States: BOOT, RUN, DONE.
  - BOOT: one cycle after reset release, no request. Then RUN.
  - RUN: issue reads.
  - DONE: entered when the fetch PC reaches MEM_WORDS*4. No requests; the FIFO keeps draining.
- Issue rule: in RUN, `mem_req`=1 iff `count + inflight − pop < FIFO_DEPTH`, where `pop = out_valid & out_ready`. On issue, `mem_addr` = fetch PC and fetch PC += 4.
- In-flight tracking: a shift register of MEM_LATENCY stages, each holding {valid, epoch, pc}. A stage whose valid bit exits the shift register pushes {mem_rdata, pc} into the FIFO only if its epoch equals the current epoch.
- Redirect in cycle t:
  - epoch toggles.
  - FIFO cleared.
  - fetch PC = `redirect_pc & ~3`.
  - State goes to RUN (also from DONE).
  - No request is issued in cycle t.
  - Old-epoch returns are dropped silently.
- Simultaneous redirect and pop: the handshake completes (decode owns the word). The FIFO is still fully cleared.
- Redirect target ≥ MEM_WORDS*4: go directly to DONE; `fetch_done`=1 next cycle.
- FIFO holds {instr, pc}. `out_*` come from the head entry. Push and pop in the same cycle are both honoured; the count is unchanged.
- Overflow cannot occur because of the issue rule. A push into a full FIFO is a design error and must be caught by a bench assertion.

## Timing
- Reset values: `mem_req`=0, `mem_addr`=RESET_PC, `out_valid`=0, `out_instr`=0, `out_pc`=0, `fetch_done`=0, state=BOOT, epoch=0, count=0, all stages invalid.
- Reset asserted mid-operation: everything returns to the reset values immediately (asynchronously). Returns already in flight are ignored.
- Cycle 0 is the first cycle after reset release (BOOT).
  - First `mem_req` in cycle 1.
  - Data captured at the end of cycle 1+MEM_LATENCY.
  - `out_valid`=1 from cycle 2+MEM_LATENCY.
- Steady state with `out_ready`=1: one instruction per cycle, no bubbles.
- Redirect at cycle t: first new-target request at t+1. Its `out_valid` appears at t+2+MEM_LATENCY. `out_valid`=0 from t+1 until then.
- `fetch_done` rises the cycle after the last-word request (address (MEM_WORDS−1)*4) is issued.

## Structure
- Package `fetch_pkg`: state enum (BOOT, RUN, DONE), `INSTR_W`=32, `ADDR_W`=32, default RESET_PC.
- Sub-module `fetch_fifo` (parameterised depth and width; push, pop, flush, count, head outputs).
- The latency shift register, the PC/state logic and the epoch bit live in `fetch_controller`.

## Test plan
- Memory words 0..3 = 8b1f03e5, f84000a4, 8b040086, f80010a6; `out_ready`=1; release reset -> `out_valid` at cycle 3 (MEM_LATENCY=1), `out_instr` 8b1f03e5, f84000a4, 8b040086, f80010a6 on consecutive cycles, `out_pc` 0, 4, 8, C.
- `out_ready`=0 for 10 cycles after start -> exactly FIFO_DEPTH (4) words are buffered and `mem_req` stops. Then raise `out_ready` -> words 0..3 in order with no loss or duplication, and fetching resumes at address 0x10.
- Redirect to 0x8 while words 0 and 1 are buffered and word 2 is in flight -> stale words are never presented. The next `out_pc` sequence is 8, C with instructions 8b040086, f80010a6.
- Run with MEM_WORDS=32 -> `fetch_done`=1 after the address 0x7C request, and no `mem_req` afterwards. A redirect to 0x4 restarts fetch, `fetch_done`=0, and the first output is f84000a4.
- Assert reset while `out_valid`=1 and requests are in flight -> all outputs reach their reset values without a clock edge. After release, fetch restarts at RESET_PC and no pre-reset data appears.
- MEM_LATENCY=3, FIFO_DEPTH=4, `out_ready` toggling every cycle -> outputs are in order with correct pc, and the bench's full-FIFO push assertion never fires.
